saradc_sar_ctrl: RTL and testbench
==================================

// Module: saradc_sar_ctrl
// PURPOSE
//   Successive-approximation sequencer for the SAR ADC macro. It drives the
//   sample switch (SARADC_CELL_INVX0_ASSW) and the binary-weighted cap-DAC
//   drivers (SARADC_CELL_INVX16_ASCAP). It strobes the comparator and resolves
//   one bit per compare, MSB first, then presents the result with a done pulse.
// PARAMETERS
//   NBITS          8   resolution; width of dac_p and result (>=2)
//   SAMPLE_CYCLES  2   cycles the sample switch is held closed (>=1)
//   SETTLE_CYCLES  1   DAC settling cycles before each compare (>=0; 0 = none)
// PORTS
//   clk      in   1      system clock, rising edge
//   rst      in   1      synchronous reset, active-high
//   start    in   1      conversion request; sampled only in IDLE
//   cmp_out  in   1      comparator decision; 1 = vin >= DAC; valid while cmp_en=1
//   sample   out  1      1 = sampling switch closed
//   dac_p    out  NBITS  cap-DAC trial code to ASCAP drivers, MSB = bit NBITS-1
//   cmp_en   out  1      comparator strobe; high exactly one cycle per bit
//   busy     out  1      high in every state except IDLE
//   done     out  1      one-cycle pulse; result is valid from this cycle onward
//   result   out  NBITS  last completed conversion; held until the next done
// BEHAVIOUR
//   - All outputs are registered. On rst all outputs are 0 and state = IDLE.
//     rst mid-conversion aborts immediately with no done pulse, and result clears.
//   - States: IDLE -> SAMPLE -> {SETTLE -> COMPARE} x NBITS -> DONE -> IDLE.
//   - IDLE: sample=0, dac_p=0, busy=0. start=1 at edge E0 -> SAMPLE.
//   - SAMPLE: sample=1, dac_p=0 for SAMPLE_CYCLES cycles. On exit sample=0,
//     bit index k=NBITS-1, dac_p = 1<<k.
//   - SETTLE: hold dac_p for SETTLE_CYCLES cycles. If SETTLE_CYCLES=0 the state
//     is skipped and control goes straight to COMPARE.
//   - COMPARE: cmp_en=1 for one cycle. At the closing edge, dac_p[k] is
//     cleared if cmp_out=0 and kept if cmp_out=1.
//     If k>0: set dac_p[k-1], k<=k-1, then go to SETTLE (or COMPARE if
//     SETTLE_CYCLES=0). If k=0: go to DONE.
//   - DONE: done=1 and result<=dac_p for one cycle, busy=1. On exit dac_p<=0.
//   - Latency: done is high in the cycle following edge
//     E0 + SAMPLE_CYCLES + NBITS*(SETTLE_CYCLES+1). Defaults give E18.
//   - start while busy is ignored and is not queued. start held high gives
//     back-to-back conversions with one IDLE cycle between them.
//   - cmp_out is ignored when cmp_en=0. A single shared down-counter of
//     $clog2(max(SAMPLE_CYCLES,SETTLE_CYCLES)+1) bits times SAMPLE and SETTLE.
// CONFIGURATION
//   SARADC_CONT_EN defined: adds input port cont (1 bit, after start).
//     If cont=1 in DONE, the next state is SAMPLE, not IDLE, and busy stays high.
//     Conversion period = SAMPLE_CYCLES + NBITS*(SETTLE_CYCLES+1) + 1 cycles.
//   SARADC_CONT_EN undefined: port cont is absent. DONE always returns to IDLE.
// TESTING
//   Comparator model in the bench: cmp_out = (vin >= dac_p) when cmp_en=1.
//   1. Defaults, vin=8'hA5, start pulse at E0 -> cmp_en pulses 8x,
//      done at E18, result=8'hA5, busy low after done.
//   2. vin=8'hFF then vin=8'h00 -> result=8'hFF then 8'h00. dac_p trial
//      sequence for 8'h00 is 80,40,20,10,08,04,02,01.
//   3. start re-pulsed at E5 during conversion of vin=8'h3C -> ignored,
//      exactly one done, result=8'h3C.
//   4. rst asserted at E10 mid-conversion -> next cycle all outputs 0, no done;
//      a following start converts normally.
//   5. SETTLE_CYCLES=0, SAMPLE_CYCLES=1, vin=8'h5A -> done at E9, result=8'h5A.
//   6. SARADC_CONT_EN with cont=1, vin stepping 8'h11,8'h22 -> done every 19
//      cycles, busy never drops, results 8'h11 then 8'h22.

Source files
------------

// File: rtl/saradc_sar_ctrl.sv
// saradc_sar_ctrl: successive-approximation sequencer for the SAR ADC macro.
// It closes the sample switch, then walks the cap-DAC trial code MSB first.
// Each bit gets optional settling time and one comparator strobe. The
// resolved code is then published on result with a one-cycle done pulse.
//
// Optional feature macro: SARADC_CONT_EN
//   When defined, the module has an extra input cont. With cont=1 in DONE,
//   the sequencer goes straight back to SAMPLE for continuous conversion.
//
// Ports:
//   clk      in   1      system clock, rising edge
//   rst      in   1      synchronous reset, active-high
//   start    in   1      conversion request, sampled only in IDLE
//   cont     in   1      (SARADC_CONT_EN only) continuous-conversion enable
//   cmp_out  in   1      comparator decision (1 = vin >= DAC), used while cmp_en=1
//   sample   out  1      sampling switch closed
//   dac_p    out  NBITS  cap-DAC trial code, MSB = bit NBITS-1
//   cmp_en   out  1      comparator strobe, one cycle per bit
//   busy     out  1      high in every state except IDLE
//   done     out  1      one-cycle conversion-complete pulse
//   result   out  NBITS  last completed conversion
module saradc_sar_ctrl #(
  parameter int unsigned NBITS         = 8,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SARADC_CONT_EN
  input  logic             cont,
`endif
  input  logic             cmp_out,
  output logic             sample,
  output logic [NBITS-1:0] dac_p,
  output logic             cmp_en,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result
);

  localparam int unsigned MAXC      = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAXC + 1);
  localparam int unsigned KW        = $clog2(NBITS);
  localparam int unsigned SAMPLE_LD = SAMPLE_CYCLES - 1;
  localparam int unsigned SETTLE_LD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_e;

  // With no settling time the bit loop runs COMPARE -> COMPARE.
  localparam state_e BIT_ENTRY = (SETTLE_CYCLES > 0) ? SETTLE : COMPARE;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [NBITS-1:0] res_q, res_d;
  logic             sample_q, sample_d;
  logic             cmp_en_q, cmp_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      dac_q    <= '0;
      res_q    <= '0;
      sample_q <= 1'b0;
      cmp_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      dac_q    <= dac_d;
      res_q    <= res_d;
      sample_q <= sample_d;
      cmp_en_q <= cmp_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, trial-code and timer logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    dac_d   = dac_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        dac_d = '0;
        if (start) begin
          state_d = SAMPLE;
          cnt_d   = CNT_W'(SAMPLE_LD);
        end
      end

      SAMPLE: begin
        if (cnt_q == '0) begin
          k_d              = KW'(NBITS - 1);
          dac_d            = '0;
          dac_d[NBITS-1]   = 1'b1;
          cnt_d            = CNT_W'(SETTLE_LD);
          state_d          = BIT_ENTRY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      COMPARE: begin
        // Resolve bit k, then either trial the next bit or finish.
        if (!cmp_out) begin
          dac_d[k_q] = 1'b0;
        end
        if (k_q == '0) begin
          res_d   = dac_d;
          state_d = DONE;
        end else begin
          dac_d[k_q - KW'(1)] = 1'b1;
          k_d                 = k_q - KW'(1);
          cnt_d               = CNT_W'(SETTLE_LD);
          state_d             = BIT_ENTRY;
        end
      end

      DONE: begin
        dac_d   = '0;
        state_d = IDLE;
`ifdef SARADC_CONT_EN
        if (cont) begin
          state_d = SAMPLE;
          cnt_d   = CNT_W'(SAMPLE_LD);
        end
`endif
      end

      default: begin
        dac_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    sample_d = (state_d == SAMPLE);
    cmp_en_d = (state_d == COMPARE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  assign sample = sample_q;
  assign dac_p  = dac_q;
  assign cmp_en = cmp_en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// Directed testbench for saradc_sar_ctrl with a behavioural comparator.
// Instance dut_a uses default timing. Instance dut_b uses SAMPLE_CYCLES=1
// and SETTLE_CYCLES=0. The continuous-conversion step is built only when
// SARADC_CONT_EN is defined.
module tb_saradc_sar_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cmp_out, sample, cmp_en, busy, done;
  logic [7:0] vin, dac_p, result;
  logic       start_b, cmp_out_b, sample_b, cmp_en_b, busy_b, done_b;
  logic [7:0] vin_b, dac_p_b, result_b;
`ifdef SARADC_CONT_EN
  logic       cont, cont_b;
`endif

  // Comparator model. Outside the strobe it returns a misleading 1.
  assign cmp_out   = cmp_en   ? (vin   >= dac_p)   : 1'b1;
  assign cmp_out_b = cmp_en_b ? (vin_b >= dac_p_b) : 1'b1;

  int nchk  = 0;
  int nfail = 0;
  logic [7:0] trial [8];

  saradc_sar_ctrl #(.NBITS(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef SARADC_CONT_EN
    .cont    (cont),
`endif
    .cmp_out (cmp_out),
    .sample  (sample),
    .dac_p   (dac_p),
    .cmp_en  (cmp_en),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  saradc_sar_ctrl #(.NBITS(8), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .start   (start_b),
`ifdef SARADC_CONT_EN
    .cont    (cont_b),
`endif
    .cmp_out (cmp_out_b),
    .sample  (sample_b),
    .dac_p   (dac_p_b),
    .cmp_en  (cmp_en_b),
    .busy    (busy_b),
    .done    (done_b),
    .result  (result_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion on dut_a with a start pulse. Optionally, start is re-pulsed
  // at edge E<repulse>. lat = n means done was seen in the cycle after E(n-1).
  task automatic conv_a(input logic [7:0] v, input int repulse,
                        output int lat, output int ncmp, output int ndone,
                        output logic busy_after);
    lat = 0; ncmp = 0; ndone = 0; busy_after = 1'b1;
    @(negedge clk);
    vin   = v;
    start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      start = (n == repulse);
      if (cmp_en) begin
        if (ncmp < 8) trial[ncmp] = dac_p;
        ncmp++;
      end
      if (done) begin
        ndone++;
        if (lat == 0) lat = n;
      end
      if (lat != 0 && n == lat + 1) busy_after = busy;
    end
  endtask

  int   lat, ncmp, ndone, d1, d2, nlow;
  logic busy_after;

  initial begin
    rst = 1'b1; start = 1'b0; vin = 8'h00; start_b = 1'b0; vin_b = 8'h00;
`ifdef SARADC_CONT_EN
    cont = 1'b0; cont_b = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_ctl", 32'({sample, cmp_en, busy, done}), 32'h0);
    check("reset_dac", 32'(dac_p), 32'h0);
    check("reset_result", 32'(result), 32'h0);
    rst = 1'b0;

    // Basic conversion with default timing.
    conv_a(8'hA5, 0, lat, ncmp, ndone, busy_after);
    check("a5_latency", 32'(lat), 32'd19);
    check("a5_ncmp", 32'(ncmp), 32'd8);
    check("a5_ndone", 32'(ndone), 32'd1);
    check("a5_result", 32'(result), 32'hA5);
    check("a5_busy_after", 32'(busy_after), 32'h0);
    check("a5_trial1", 32'(trial[1]), 32'hC0);
    check("a5_trial7", 32'(trial[7]), 32'hA5);

    // Full-scale inputs.
    conv_a(8'hFF, 0, lat, ncmp, ndone, busy_after);
    check("ff_result", 32'(result), 32'hFF);
    conv_a(8'h00, 0, lat, ncmp, ndone, busy_after);
    check("00_result", 32'(result), 32'h00);
    for (int i = 0; i < 8; i++) check("00_trial", 32'(trial[i]), 32'h80 >> i);

    // start during a conversion is ignored.
    conv_a(8'h3C, 5, lat, ncmp, ndone, busy_after);
    check("3c_ndone", 32'(ndone), 32'd1);
    check("3c_latency", 32'(lat), 32'd19);
    check("3c_result", 32'(result), 32'h3C);

    // Reset applied at E10 aborts the conversion.
    @(negedge clk);
    vin = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ctl", 32'({sample, cmp_en, busy, done}), 32'h0);
    check("rst_dac", 32'(dac_p), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    rst = 1'b0;
    nlow = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done || busy) nlow++;
    end
    check("rst_no_activity", 32'(nlow), 32'd0);
    conv_a(8'hC3, 0, lat, ncmp, ndone, busy_after);
    check("c3_latency", 32'(lat), 32'd19);
    check("c3_result", 32'(result), 32'hC3);

    // Holding start high gives back-to-back conversions with one IDLE cycle between them.
    @(negedge clk);
    vin = 8'h5B; start = 1'b1;
    d1 = 0; d2 = 0; nlow = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = n;
        else if (d2 == 0) d2 = n;
      end
      if (d1 != 0 && d2 == 0 && !busy) nlow++;
    end
    start = 1'b0;
    check("b2b_first", 32'(d1), 32'd19);
    check("b2b_period", 32'(d2 - d1), 32'd20);
    check("b2b_idle", 32'(nlow), 32'd1);
    check("b2b_result", 32'(result), 32'h5B);
    repeat (30) @(negedge clk);

    // Minimum timing: one sample cycle and no settling.
    @(negedge clk);
    vin_b = 8'h5A; start_b = 1'b1;
    lat = 0; ncmp = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (cmp_en_b) ncmp++;
      if (done_b && lat == 0) lat = n;
    end
    check("b_latency", 32'(lat), 32'd10);
    check("b_ncmp", 32'(ncmp), 32'd8);
    check("b_result", 32'(result_b), 32'h5A);

`ifdef SARADC_CONT_EN
    // Continuous conversion: period 19, busy stays high.
    @(negedge clk);
    cont = 1'b1; vin = 8'h11; start = 1'b1;
    d1 = 0; d2 = 0; nlow = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (d2 == 0 && !busy) nlow++;
      if (done) begin
        if (d1 == 0) begin
          d1 = n;
          check("cont_result1", 32'(result), 32'h11);
          vin = 8'h22;
        end else if (d2 == 0) begin
          d2 = n;
          check("cont_result2", 32'(result), 32'h22);
          cont = 1'b0;
        end
      end
    end
    check("cont_period", 32'(d2 - d1), 32'd19);
    check("cont_busy_low", 32'(nlow), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
